// File: rtl/axis_width_packer.sv
// Packs IN_WIDTH-bit AXIS beats into IN_WIDTH*RATIO-bit words ahead of the async FIFO.
// Partial words are flushed on s_tlast, and any unfilled lanes carry keep=0.
module axis_width_packer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                         wclk,
  input  logic                         wrst_n,
  input  logic [IN_WIDTH-1:0]          s_tdata,
  input  logic [IN_WIDTH/8-1:0]        s_tkeep,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  input  logic                         s_tlast,
  output logic [IN_WIDTH*RATIO-1:0]    m_tdata,
  output logic [IN_WIDTH*RATIO/8-1:0]  m_tkeep,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         m_tlast
);

  localparam int KEEP_W     = IN_WIDTH / 8;
  localparam int OUT_W      = IN_WIDTH * RATIO;
  localparam int OUT_KEEP_W = KEEP_W * RATIO;
  localparam int CNT_W      = $clog2(RATIO);
  localparam int ACC_LANES  = RATIO - 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]              cnt_r;
  logic [ACC_LANES*IN_WIDTH-1:0] acc_data_r;
  logic [ACC_LANES*KEEP_W-1:0]   acc_keep_r;

  logic              accept_s;
  logic              complete_s;
  logic [OUT_W-1:0]      word_data_s;
  logic [OUT_KEEP_W-1:0] word_keep_s;

  // A new beat may enter whenever the output register is empty or draining this cycle.
  assign s_tready   = ~m_tvalid | m_tready;
  assign accept_s   = s_tvalid & s_tready;
  assign complete_s = accept_s & (s_tlast | (cnt_r == LAST_LANE));

  // Assemble the candidate word: filled lanes below cnt, current beat in lane cnt, zeros above.
  always_comb begin
    word_data_s = {OUT_W{1'b0}};
    word_keep_s = {OUT_KEEP_W{1'b0}};
    for (int i = 0; i < ACC_LANES; i++) begin
      if (i < int'(cnt_r)) begin
        word_data_s[i*IN_WIDTH +: IN_WIDTH] = acc_data_r[i*IN_WIDTH +: IN_WIDTH];
        word_keep_s[i*KEEP_W +: KEEP_W]     = acc_keep_r[i*KEEP_W +: KEEP_W];
      end else begin
        word_data_s[i*IN_WIDTH +: IN_WIDTH] = {IN_WIDTH{1'b0}};
        word_keep_s[i*KEEP_W +: KEEP_W]     = {KEEP_W{1'b0}};
      end
    end
    word_data_s[int'(cnt_r)*IN_WIDTH +: IN_WIDTH] = s_tdata;
    word_keep_s[int'(cnt_r)*KEEP_W +: KEEP_W]     = s_tkeep;
  end

  // Lane counter and accumulator; stale data above cnt is masked out when the word forms.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      cnt_r      <= {CNT_W{1'b0}};
      acc_data_r <= {(ACC_LANES*IN_WIDTH){1'b0}};
      acc_keep_r <= {(ACC_LANES*KEEP_W){1'b0}};
    end else if (complete_s) begin
      cnt_r      <= {CNT_W{1'b0}};
      acc_keep_r <= {(ACC_LANES*KEEP_W){1'b0}};
    end else if (accept_s) begin
      acc_data_r[int'(cnt_r)*IN_WIDTH +: IN_WIDTH] <= s_tdata;
      acc_keep_r[int'(cnt_r)*KEEP_W +: KEEP_W]     <= s_tkeep;
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Output word register: reload on completion, otherwise empty on handshake and hold while stalled.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= {OUT_W{1'b0}};
      m_tkeep  <= {OUT_KEEP_W{1'b0}};
      m_tlast  <= 1'b0;
    end else if (complete_s) begin
      m_tvalid <= 1'b1;
      m_tdata  <= word_data_s;
      m_tkeep  <= word_keep_s;
      m_tlast  <= s_tlast;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end else begin
      m_tvalid <= m_tvalid;
    end
  end

endmodule

// File: tb/tb_axis_width_packer.sv
// Randomized and directed bench for axis_width_packer (IN_WIDTH=8, RATIO=4) against a
// queue-based model that regroups accepted beats into words by the packing rules.
module tb_axis_width_packer;

  localparam int IN_WIDTH = 8;
  localparam int RATIO    = 4;

  logic        wclk;
  logic        wrst_n;
  logic [7:0]  s_tdata;
  logic [0:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  word_t      exp_q[$];
  word_t      obs_q[$];
  logic [7:0] pend_d[$];
  logic       pend_k[$];
  logic       last_acc;
  int         n_acc;
  int         tests_run;
  int         tests_failed;

  axis_width_packer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare DUT against the model, advance the model.
  task automatic cycle(input logic v, input logic [7:0] d, input logic k, input logic l,
                       input logic rdy);
    word_t w;
    logic  exp_valid;
    logic  exp_ready;
    @(negedge wclk);
    s_tvalid = v; s_tdata = d; s_tkeep = k; s_tlast = l; m_tready = rdy;
    #1;
    exp_valid = (exp_q.size() != 0);
    check("m_tvalid", m_tvalid, exp_valid);
    if (exp_valid) begin
      check("m_tdata", m_tdata, exp_q[0].d);
      check("m_tkeep", m_tkeep, exp_q[0].k);
      check("m_tlast", m_tlast, exp_q[0].l);
    end
    exp_ready = !exp_valid || rdy;
    check("s_tready", s_tready, exp_ready);
    if (exp_valid && rdy) begin
      obs_q.push_back({m_tdata, m_tkeep, m_tlast});
      void'(exp_q.pop_front());
    end
    last_acc = v && exp_ready;
    if (last_acc) begin
      pend_d.push_back(d);
      pend_k.push_back(k);
      n_acc++;
      if (l || pend_d.size() == RATIO) begin
        w = '0;
        for (int i = 0; i < pend_d.size(); i++) begin
          w.d[i*8 +: 8] = pend_d[i];
          w.k[i]        = pend_k[i];
        end
        w.l = l;
        exp_q.push_back(w);
        pend_d.delete();
        pend_k.delete();
      end
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic k, input logic l, input logic rdy);
    for (int n = 0; n < 100; n++) begin
      cycle(1'b1, d, k, l, rdy);
      if (last_acc) return;
    end
    check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_word(input int idx, input logic [31:0] d, input logic [3:0] k,
                            input logic l);
    if (idx < obs_q.size()) begin
      check("word_data", obs_q[idx].d, d);
      check("word_keep", obs_q[idx].k, k);
      check("word_last", obs_q[idx].l, l);
    end else begin
      check("word_missing", obs_q.size(), idx + 1);
    end
  endtask

  initial begin
    logic [7:0] b;
    int cyc;
    tests_run = 0; tests_failed = 0; n_acc = 0; last_acc = 1'b0;
    wrst_n = 1'b0;
    s_tvalid = 1'b0; s_tdata = 8'h00; s_tkeep = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    repeat (3) @(posedge wclk);
    #1;
    check("rst_tvalid", m_tvalid, 1'b0);
    check("rst_tdata", m_tdata, 32'h0);
    check("rst_tkeep", m_tkeep, 4'h0);
    check("rst_tlast", m_tlast, 1'b0);
    @(negedge wclk);
    wrst_n = 1'b1;

    // Two full words from an 8-beat packet.
    obs_q.delete();
    for (int i = 1; i <= 8; i++) begin
      b = 8'(i * 17);
      cycle(1'b1, b, 1'b1, i == 8, 1'b1);
      check("t1_accept", last_acc, 1'b1);
    end
    drain(3);
    check_word(0, 32'h44332211, 4'hF, 1'b0);
    check_word(1, 32'h88776655, 4'hF, 1'b1);

    // Short packets flushed by tlast.
    obs_q.delete();
    send_beat(8'hA1, 1'b1, 1'b1, 1'b1);
    send_beat(8'hB1, 1'b1, 1'b0, 1'b1);
    send_beat(8'hB2, 1'b1, 1'b1, 1'b1);
    send_beat(8'hC1, 1'b1, 1'b0, 1'b1);
    send_beat(8'hC2, 1'b1, 1'b0, 1'b1);
    send_beat(8'hC3, 1'b1, 1'b1, 1'b1);
    drain(3);
    check_word(0, 32'h000000A1, 4'h1, 1'b1);
    check_word(1, 32'h0000B2B1, 4'h3, 1'b1);
    check_word(2, 32'h00C3C2C1, 4'h7, 1'b1);

    // Backpressure: a pending word stalls the input for 20 cycles.
    obs_q.delete();
    for (int i = 0; i < 4; i++) send_beat(8'(8'h11 + i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'h21, 1'b1, 1'b0, 1'b0);
      check("bp_stall", last_acc, 1'b0);
    end
    for (int i = 0; i < 4; i++) send_beat(8'(8'h21 + i), 1'b1, i == 3, 1'b1);
    drain(3);
    check_word(0, 32'h14131211, 4'hF, 1'b0);
    check_word(1, 32'h24232221, 4'hF, 1'b1);

    // Back-to-back words with continuous valid and ready.
    obs_q.delete();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(8'h30 + i), 1'b1, 1'b0, 1'b1);
      check("b2b_accept", last_acc, 1'b1);
    end
    drain(3);
    check_word(3, 32'h3F3E3D3C, 4'hF, 1'b0);

    // Asynchronous reset mid-word discards the partial beats.
    obs_q.delete();
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h66, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h88, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
    @(negedge wclk);
    s_tvalid = 1'b0;
    #2;
    wrst_n = 1'b0;
    #1;
    check("amr_tvalid", m_tvalid, 1'b0);
    check("amr_tdata", m_tdata, 32'h0);
    check("amr_tkeep", m_tkeep, 4'h0);
    exp_q.delete(); pend_d.delete(); pend_k.delete(); obs_q.delete();
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    for (int i = 1; i <= 4; i++) send_beat(8'(i), 1'b1, 1'b0, 1'b1);
    drain(3);
    check_word(0, 32'h04030201, 4'hF, 1'b0);
    check("amr_count", obs_q.size(), 1);

    // Random traffic against the model.
    n_acc = 0;
    cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 9) < 7);
      cyc++;
    end
    check("rand_budget", n_acc >= 10000, 1'b1);
    send_beat(8'hEE, 1'b1, 1'b1, 1'b1);
    drain(4);
    check("rand_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
